// File: rtl/image_loader.sv
// LOAD-phase responder: assembles an IMG_W x IMG_H binary image from IN_W-bit beats.
// Optional build macro IMAGE_LOADER_CHECKSUM_EN adds an XOR checksum of accepted beats.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for the controller to enter LOAD; beats ignored
// S_FILL | ready=1; each valid beat is written at the next pixel slot
// S_WAIT | image complete and held; leaves when controller exits LOAD
module image_loader #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int IN_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             state,
  input  logic [IN_W-1:0]        data_in,
  input  logic                   data_valid,
  output logic                   ready,
  output logic                   load_done,
  output logic [IMG_W*IMG_H-1:0] image,
  output logic [IN_W-1:0]        checksum
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int BEATS = (NPIX + IN_W - 1) / IN_W;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [2:0] CTRL_LOAD = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_WAIT = 2'd2
  } fsm_t;

  fsm_t             fsm_q;
  fsm_t             fsm_d;
  logic [CNT_W-1:0] beat_cnt;
  logic             load_seen;
  logic             last_beat;
  logic             start;
  logic             accept;

  assign load_seen = (state == CTRL_LOAD);
  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  // A beat only counts while the controller is still in LOAD, so an abort
  // on the same edge as a beat wins and the beat is dropped.
  always_comb begin
    fsm_d  = fsm_q;
    ready  = 1'b0;
    start  = 1'b0;
    accept = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (load_seen) begin
          fsm_d = S_FILL;
          start = 1'b1;
        end
      end
      S_FILL: begin
        ready = 1'b1;
        if (!load_seen) begin
          fsm_d = S_IDLE;
        end else if (data_valid) begin
          accept = 1'b1;
          if (last_beat) begin
            fsm_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!load_seen) begin
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= S_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (start) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_done <= 1'b0;
    end else begin
      load_done <= accept && last_beat;
    end
  end

  // Per-pixel decode: only pixels that exist are written, so tail bits of a
  // partial final beat fall away without any out-of-range write.
  always_ff @(posedge clk) begin
    if (rst) begin
      image <= '0;
    end else if (accept) begin
      for (int p = 0; p < NPIX; p++) begin
        if (beat_cnt == CNT_W'(p / IN_W)) begin
          image[p] <= data_in[p % IN_W];
        end
      end
    end
  end

`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [IN_W-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (start) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= csum_q ^ data_in;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: randomized beats and gaps against a
// beat-list reference model of the pixel buffer and checksum.
module tb_image_loader;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int IN_W  = 8;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int BEATS = (NPIX + IN_W - 1) / IN_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      state;
  logic [IN_W-1:0] data_in;
  logic            data_valid;
  logic            ready;
  logic            load_done;
  logic [NPIX-1:0] image;
  logic [IN_W-1:0] checksum;

  logic [NPIX-1:0] exp_img;
  logic [IN_W-1:0] exp_csum;
  int              accepted;
  int              n_tests = 0;
  int              n_fail  = 0;

  image_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .IN_W(IN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .data_in    (data_in),
    .data_valid (data_valid),
    .ready      (ready),
    .load_done  (load_done),
    .image      (image),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NPIX-1:0] got, input logic [NPIX-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IN_W-1:0] exp_checksum();
`ifdef IMAGE_LOADER_CHECKSUM_EN
    return exp_csum;
`else
    return '0;
`endif
  endfunction

  task automatic check_outputs(input string tag, input logic exp_ready, input logic exp_done);
    check({tag, ".ready"}, NPIX'(ready), NPIX'(exp_ready));
    check({tag, ".load_done"}, NPIX'(load_done), NPIX'(exp_done));
    check({tag, ".image"}, image, exp_img);
    check({tag, ".checksum"}, NPIX'(checksum), NPIX'(exp_checksum()));
  endtask

  // Reference: the k-th accepted beat of a load owns pixels k*IN_W .. k*IN_W+IN_W-1.
  task automatic model_beat(input logic [IN_W-1:0] v);
    for (int i = 0; i < IN_W; i++) begin
      if (accepted * IN_W + i < NPIX) exp_img[accepted * IN_W + i] = v[i];
    end
    exp_csum = exp_csum ^ v;
    accepted++;
  endtask

  function automatic logic [IN_W-1:0] beat_val(input int kind, input int idx);
    case (kind)
      0:       return 8'hA5;
      1:       return IN_W'(idx);
      2:       return 8'hFF;
      3:       return 8'h00;
      default: return IN_W'($urandom);
    endcase
  endfunction

  task automatic enter_load();
    state      = 3'b001;
    data_valid = 1'b0;
    tick();
    accepted = 0;
    exp_csum = '0;
    check_outputs("enter_load", 1'b1, 1'b0);
  endtask

  task automatic go_idle();
    state      = 3'b000;
    data_valid = 1'b0;
    tick();
    check_outputs("go_idle", 1'b0, 1'b0);
  endtask

  task automatic send_beats(input int n, input int kind, input int gap_min, input int gap_max,
                            input string tag);
    for (int b = 0; b < n; b++) begin
      int gap;
      gap = int'($urandom_range(gap_max, gap_min));
      for (int g = 0; g < gap; g++) begin
        data_valid = 1'b0;
        data_in    = IN_W'($urandom);
        tick();
        check_outputs({tag, ".gap"}, 1'b1, 1'b0);
      end
      data_in    = beat_val(kind, accepted);
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      model_beat(data_in);
      if (accepted == BEATS) check_outputs({tag, ".last"}, 1'b0, 1'b1);
      else                   check_outputs({tag, ".beat"}, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    state      = 3'b001;
    data_valid = 1'b1;
    data_in    = IN_W'($urandom);
    exp_img    = '0;
    exp_csum   = '0;
    accepted   = 0;

    // Reset held with LOAD and valid beats present
    repeat (2) begin
      tick();
      check_outputs("reset", 1'b0, 1'b0);
    end
    rst = 1'b0;
    tick();
    check_outputs("rst_release", 1'b1, 1'b0);
    go_idle();

    // Beats outside LOAD are ignored
    for (int i = 0; i < 10; i++) begin
      state      = 3'b000;
      data_in    = 8'hFF;
      data_valid = 1'b1;
      tick();
      check_outputs("idle_beats", 1'b0, 1'b0);
    end
    data_valid = 1'b0;

    // Back-to-back A5 load
    enter_load();
    send_beats(BEATS, 0, 0, 0, "a5");
    tick();
    check_outputs("a5_after", 1'b0, 1'b0);
    check("a5_pattern", image, {BEATS{8'hA5}});
    go_idle();

    // Ramp 0..97 with a beat every third cycle
    enter_load();
    send_beats(BEATS, 1, 2, 2, "ramp");
    tick();
    check_outputs("ramp_after", 1'b0, 1'b0);
    go_idle();

    // Abort after 40 beats, with a beat coinciding with the abort edge
    enter_load();
    send_beats(40, 2, 0, 2, "ff_part");
    state      = 3'b000;
    data_in    = IN_W'($urandom_range(255, 1));
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check_outputs("abort", 1'b0, 1'b0);
    repeat (3) begin
      tick();
      check_outputs("post_abort", 1'b0, 1'b0);
    end
    enter_load();
    send_beats(BEATS, 3, 0, 1, "zero");
    tick();
    check_outputs("zero_after", 1'b0, 1'b0);
    check("zero_image", image, '0);

    // Controller lingers in LOAD after completion
    for (int i = 0; i < 20; i++) begin
      state      = 3'b001;
      data_valid = 1'($urandom);
      data_in    = IN_W'($urandom);
      tick();
      check_outputs("wait_hold", 1'b0, 1'b0);
    end
    go_idle();

    // Random data with random gaps
    enter_load();
    send_beats(BEATS, 4, 0, 3, "rand");
    tick();
    check_outputs("rand_after", 1'b0, 1'b0);
    go_idle();

    // Reset in the middle of a fill
    enter_load();
    send_beats(30, 4, 0, 1, "pre_rst");
    rst        = 1'b1;
    data_valid = 1'b1;
    data_in    = IN_W'($urandom);
    tick();
    exp_img  = '0;
    exp_csum = '0;
    check_outputs("mid_rst", 1'b0, 1'b0);
    rst        = 1'b0;
    state      = 3'b000;
    data_valid = 1'b0;
    tick();
    check_outputs("after_rst", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
